// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, state codes,
// ALU operand/operation selects and the opcode-class decode.
package ctrl_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [2:0] S_RST    = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

    localparam logic [1:0] SRCB_RS2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LD,
        CLS_SD,
        CLS_BEQ
    } op_class_e;

    function automatic op_class_e op_class(input logic [6:0] op, input logic en_itype);
        op_class_e c;
        case (op)
            OP_RTYPE: c = CLS_R;
            OP_ITYPE: c = en_itype ? CLS_I : CLS_NONE;
            OP_LD:    c = CLS_LD;
            OP_SD:    c = CLS_SD;
            OP_BEQ:   c = CLS_BEQ;
            default:  c = CLS_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state watchdog: down-counter reloaded on clear, flags expiry in
// the cycle that would reach MEM_TIMEOUT waiting cycles. MEM_TIMEOUT=0 never expires.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic cnt_en,
    output logic expired
);

    localparam int CW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int LOAD_I = (MEM_TIMEOUT > 0) ? int'(MEM_TIMEOUT) - 1 : 0;
    localparam logic [CW-1:0] LOAD = CW'(LOAD_I);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = LOAD;
        end else if (cnt_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count only matters while still waiting, so a ready in that cycle wins.
    assign expired = (MEM_TIMEOUT != 0) && cnt_en && (cnt_q == '0);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle main controller for the RV64 subset datapath.
//   state  | meaning
//   RST    | post-reset idle, all outputs low
//   FETCH  | read instruction at PC, PC+4 on mem_ready
//   DECODE | latch opcode, compute branch target, legality check
//   EXEC   | ALU operation per opcode class; beq retires here
//   MEM    | ld/sd data access with wait states; sd retires here
//   WB     | register write-back; retires
//   TRAP   | illegal opcode or memory timeout, wait for trap_clr
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int          ALUOP_W     = 2,
    parameter bit          EN_ITYPE    = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int          CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    input  logic               trap_clr,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               Branch,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               instr_done,
    output logic               trap,
    output logic [CNT_W-1:0]   retired_cnt
);

    logic [2:0]       state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    op_class_e        cls;
    logic             in_wait_state, tmr_clr, tmr_expired;

    assign cls           = op_class(op_q, EN_ITYPE);
    assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEM);
    // Reload on every state change so both FETCH and MEM start a fresh budget.
    assign tmr_clr       = (state_d != state_q) || !in_wait_state;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .cnt_en  (in_wait_state && !mem_ready),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        Branch      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = '0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        instr_done  = 1'b0;
        trap        = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ALUOp   = ALUOP_W'(ALUOP_ADD);
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (tmr_expired) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH1;
                ALUOp   = ALUOP_W'(ALUOP_ADD);
                op_d    = opcode;
                state_d = (op_class(opcode, EN_ITYPE) == CLS_NONE) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                case (cls)
                    CLS_R: begin
                        ALUOp   = ALUOP_W'(ALUOP_RFUNCT);
                        state_d = S_WB;
                    end
                    CLS_I: begin
                        ALUSrcB = SRCB_IMM;
                        ALUOp   = ALUOP_W'(ALUOP_IFUNCT);
                        state_d = S_WB;
                    end
                    CLS_LD, CLS_SD: begin
                        ALUSrcB = SRCB_IMM;
                        ALUOp   = ALUOP_W'(ALUOP_ADD);
                        state_d = S_MEM;
                    end
                    CLS_BEQ: begin
                        ALUOp       = ALUOP_W'(ALUOP_SUB);
                        Branch      = 1'b1;
                        PCWriteCond = zero;
                        instr_done  = 1'b1;
                        state_d     = S_FETCH;
                    end
                    default: begin
                        ALUSrcA = 1'b0;
                        state_d = S_TRAP;
                    end
                endcase
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = (cls == CLS_LD);
                MemWrite = (cls != CLS_LD);
                if (mem_ready) begin
                    if (cls == CLS_LD) begin
                        state_d = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end else if (tmr_expired) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = (cls == CLS_LD);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
                if (trap_clr) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_RST;
        endcase
    end

    assign retired_cnt_d = instr_done ? retired_cnt_q + CNT_W'(1) : retired_cnt_q;
    assign retired_cnt   = retired_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RST;
            op_q          <= '0;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

endmodule
